// File: rtl/decode_output_queue_pkg.sv
// Shared decode package: field widths, functional-unit ids, register access
// encodings and the packed decoded-bundle type used by the format decoders
// and the decode output queue.
package decode_output_queue_pkg;

  localparam int ADDRESS_WIDTH          = 64;
  localparam int OPCODE_SIZE            = 12;
  localparam int FUNC_UNIT_CODE_SIZE    = 3;
  localparam int INST_COUNTER_WIDTH     = 64;
  localparam int INST_MIN_ID_WIDTH      = 5;
  localparam int PID_SIZE               = 20;
  localparam int TID_SIZE               = 16;
  localparam int REG_SIZE               = 5;
  localparam int REG_ACCESS_PATTERN_SIZE = 2;
  localparam int BODY_WIDTH             = 4 * REG_SIZE + 1;

  localparam int QUEUE_DEPTH  = 8;
  localparam int SKID_ENTRIES = 2;

  // Functional-unit ids
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_FX     = 3'd0;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_FP     = 3'd1;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_VX     = 3'd2;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_CR     = 3'd3;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_LS     = 3'd4;
  localparam logic [FUNC_UNIT_CODE_SIZE-1:0] FU_BRANCH = 3'd6;

  // Operand register access pattern (regRead / regWrite)
  localparam logic [REG_ACCESS_PATTERN_SIZE-1:0] REG_NONE       = 2'b00;
  localparam logic [REG_ACCESS_PATTERN_SIZE-1:0] REG_READ       = 2'b01;
  localparam logic [REG_ACCESS_PATTERN_SIZE-1:0] REG_WRITE      = 2'b10;
  localparam logic [REG_ACCESS_PATTERN_SIZE-1:0] REG_READ_WRITE = 2'b11;

  // 224 bits at default widths
  typedef struct packed {
    logic [OPCODE_SIZE-1:0]             opcode;
    logic [ADDRESS_WIDTH-1:0]           instruction_address;
    logic [FUNC_UNIT_CODE_SIZE-1:0]     functional_unit_type;
    logic [INST_COUNTER_WIDTH-1:0]      inst_maj_id;
    logic [INST_MIN_ID_WIDTH-1:0]       inst_min_id;
    logic [INST_MIN_ID_WIDTH-1:0]       num_micro_ops;
    logic                               is_64bit;
    logic [PID_SIZE-1:0]                inst_pid;
    logic [TID_SIZE-1:0]                inst_tid;
    logic [REG_ACCESS_PATTERN_SIZE-1:0] op1rw;
    logic [REG_ACCESS_PATTERN_SIZE-1:0] op2rw;
    logic [REG_ACCESS_PATTERN_SIZE-1:0] op3rw;
    logic [REG_ACCESS_PATTERN_SIZE-1:0] op4rw;
    logic                               op1_is_reg;
    logic                               op2_is_reg;
    logic                               op3_is_reg;
    logic                               op4_is_reg;
    logic                               modifies_cr;
    logic [BODY_WIDTH-1:0]              instruction_body;
  } decoded_bundle_t;

  localparam int BUNDLE_WIDTH = $bits(decoded_bundle_t);

endpackage

// File: rtl/decode_output_queue_if.sv
// Decoder-to-queue-to-dispatch bundle interface.
// slave  : the queue (consumes decoder fields, produces head fields).
// master : the surroundings (decoder + dispatch side).
// Handshake: the push side has no back-pressure handshake; enable_i pushes
// unconditionally and stall_o is an early warning the decoder must honour on
// its next edge. The pop side is valid/ready: a head entry transfers on a
// rising edge where valid_o & ready_i; while valid_o=1 and ready_i=0 the
// head fields and valid_o hold stable.
interface decode_output_queue_if #(
  parameter int QUEUE_DEPTH = decode_output_queue_pkg::QUEUE_DEPTH
);
  import decode_output_queue_pkg::*;

  localparam int COUNT_W = $clog2(QUEUE_DEPTH) + 1;

  logic                               flush_i;
  logic                               enable_i;
  logic [OPCODE_SIZE-1:0]             opcode_i;
  logic [ADDRESS_WIDTH-1:0]           instructionAddress_i;
  logic [FUNC_UNIT_CODE_SIZE-1:0]     functionalUnitType_i;
  logic [INST_COUNTER_WIDTH-1:0]      instMajId_i;
  logic [INST_MIN_ID_WIDTH-1:0]       instMinId_i;
  logic [INST_MIN_ID_WIDTH-1:0]       numMicroOps_i;
  logic                               is64Bit_i;
  logic [PID_SIZE-1:0]                instPid_i;
  logic [TID_SIZE-1:0]                instTid_i;
  logic [REG_ACCESS_PATTERN_SIZE-1:0] op1rw_i, op2rw_i, op3rw_i, op4rw_i;
  logic                               op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i;
  logic                               modifiesCR_i;
  logic [BODY_WIDTH-1:0]              instructionBody_i;

  logic                               stall_o;
  logic                               valid_o;
  logic                               ready_i;
  logic [OPCODE_SIZE-1:0]             opcode_o;
  logic [ADDRESS_WIDTH-1:0]           instructionAddress_o;
  logic [FUNC_UNIT_CODE_SIZE-1:0]     functionalUnitType_o;
  logic [INST_COUNTER_WIDTH-1:0]      instMajId_o;
  logic [INST_MIN_ID_WIDTH-1:0]       instMinId_o;
  logic [INST_MIN_ID_WIDTH-1:0]       numMicroOps_o;
  logic                               is64Bit_o;
  logic [PID_SIZE-1:0]                instPid_o;
  logic [TID_SIZE-1:0]                instTid_o;
  logic [REG_ACCESS_PATTERN_SIZE-1:0] op1rw_o, op2rw_o, op3rw_o, op4rw_o;
  logic                               op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o;
  logic                               modifiesCR_o;
  logic [BODY_WIDTH-1:0]              instructionBody_o;
  logic [COUNT_W-1:0]                 count_o;
  logic                               overflow_o;

  modport slave (
    input  flush_i, enable_i, ready_i,
    input  opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
           instMinId_i, numMicroOps_i, is64Bit_i, instPid_i, instTid_i,
           op1rw_i, op2rw_i, op3rw_i, op4rw_i,
           op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i,
           modifiesCR_i, instructionBody_i,
    output stall_o, valid_o, count_o, overflow_o,
    output opcode_o, instructionAddress_o, functionalUnitType_o, instMajId_o,
           instMinId_o, numMicroOps_o, is64Bit_o, instPid_o, instTid_o,
           op1rw_o, op2rw_o, op3rw_o, op4rw_o,
           op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o,
           modifiesCR_o, instructionBody_o
  );

  modport master (
    output flush_i, enable_i, ready_i,
    output opcode_i, instructionAddress_i, functionalUnitType_i, instMajId_i,
           instMinId_i, numMicroOps_i, is64Bit_i, instPid_i, instTid_i,
           op1rw_i, op2rw_i, op3rw_i, op4rw_i,
           op1IsReg_i, op2IsReg_i, op3IsReg_i, op4IsReg_i,
           modifiesCR_i, instructionBody_i,
    input  stall_o, valid_o, count_o, overflow_o,
    input  opcode_o, instructionAddress_o, functionalUnitType_o, instMajId_o,
           instMinId_o, numMicroOps_o, is64Bit_o, instPid_o, instTid_o,
           op1rw_o, op2rw_o, op3rw_o, op4rw_o,
           op1IsReg_o, op2IsReg_o, op3IsReg_o, op4IsReg_o,
           modifiesCR_o, instructionBody_o
  );

endinterface

// File: rtl/decode_output_queue_ram.sv
// Storage array for the decode output queue: one synchronous write port,
// one asynchronous read port. Contents are intentionally not reset.
// Ports: clock_i, we_i/waddr_i/wdata_i (write), raddr_i -> rdata_o (read).
module decode_queue_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 224,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/decode_output_queue.sv
// Decode output queue: circular FIFO of decoded bundles between the format
// decoders and dispatch. First-word-fall-through head, early stall with a
// skid margin for the decoders' registered output, sticky overflow flag.
// Ports: clock_i, reset_i (async active-low), q_if (slave modport: push
// fields, flush, head fields, valid/ready, stall, count, overflow).
module decode_output_queue
  import decode_output_queue_pkg::*;
#(
  parameter int queueDepth  = QUEUE_DEPTH,
  parameter int skidEntries = SKID_ENTRIES
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  decode_output_queue_if.slave q_if
);

  localparam int AW = $clog2(queueDepth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(queueDepth);
  localparam logic [CW-1:0] SKID_C  = CW'(skidEntries);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop, full, accept;

  decoded_bundle_t in_b, head_b;

  assign push   = q_if.enable_i;
  assign pop    = (count_q != '0) & q_if.ready_i;
  assign full   = (count_q == DEPTH_C);
  // A pop in the same cycle frees the slot, so a push into a full queue is
  // still accepted then.
  assign accept = push & (~full | pop);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (q_if.flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (accept) wptr_d = wptr_q + 1'b1;
      if (pop)    rptr_d = rptr_q + 1'b1;
      if (accept && !pop)      count_d = count_q + 1'b1;
      else if (!accept && pop) count_d = count_q - 1'b1;
      if (push && full && !pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    in_b.opcode               = q_if.opcode_i;
    in_b.instruction_address  = q_if.instructionAddress_i;
    in_b.functional_unit_type = q_if.functionalUnitType_i;
    in_b.inst_maj_id          = q_if.instMajId_i;
    in_b.inst_min_id          = q_if.instMinId_i;
    in_b.num_micro_ops        = q_if.numMicroOps_i;
    in_b.is_64bit             = q_if.is64Bit_i;
    in_b.inst_pid             = q_if.instPid_i;
    in_b.inst_tid             = q_if.instTid_i;
    in_b.op1rw                = q_if.op1rw_i;
    in_b.op2rw                = q_if.op2rw_i;
    in_b.op3rw                = q_if.op3rw_i;
    in_b.op4rw                = q_if.op4rw_i;
    in_b.op1_is_reg           = q_if.op1IsReg_i;
    in_b.op2_is_reg           = q_if.op2IsReg_i;
    in_b.op3_is_reg           = q_if.op3IsReg_i;
    in_b.op4_is_reg           = q_if.op4IsReg_i;
    in_b.modifies_cr          = q_if.modifiesCR_i;
    in_b.instruction_body     = q_if.instructionBody_i;
  end

  decode_queue_ram #(
    .DEPTH (queueDepth),
    .WIDTH (BUNDLE_WIDTH)
  ) u_ram (
    .clock_i (clock_i),
    .we_i    (accept & ~q_if.flush_i),
    .waddr_i (wptr_q),
    .wdata_i (in_b),
    .raddr_i (rptr_q),
    .rdata_o (head_b)
  );

  // Stall from registered occupancy only, so it never depends on ready_i.
  assign q_if.stall_o    = (DEPTH_C - count_q) <= SKID_C;
  assign q_if.valid_o    = (count_q != '0);
  assign q_if.count_o    = count_q;
  assign q_if.overflow_o = overflow_q;

  assign q_if.opcode_o             = head_b.opcode;
  assign q_if.instructionAddress_o = head_b.instruction_address;
  assign q_if.functionalUnitType_o = head_b.functional_unit_type;
  assign q_if.instMajId_o          = head_b.inst_maj_id;
  assign q_if.instMinId_o          = head_b.inst_min_id;
  assign q_if.numMicroOps_o        = head_b.num_micro_ops;
  assign q_if.is64Bit_o            = head_b.is_64bit;
  assign q_if.instPid_o            = head_b.inst_pid;
  assign q_if.instTid_o            = head_b.inst_tid;
  assign q_if.op1rw_o              = head_b.op1rw;
  assign q_if.op2rw_o              = head_b.op2rw;
  assign q_if.op3rw_o              = head_b.op3rw;
  assign q_if.op4rw_o              = head_b.op4rw;
  assign q_if.op1IsReg_o           = head_b.op1_is_reg;
  assign q_if.op2IsReg_o           = head_b.op2_is_reg;
  assign q_if.op3IsReg_o           = head_b.op3_is_reg;
  assign q_if.op4IsReg_o           = head_b.op4_is_reg;
  assign q_if.modifiesCR_o         = head_b.modifies_cr;
  assign q_if.instructionBody_o    = head_b.instruction_body;

endmodule

// File: tb/tb_decode_output_queue.sv
module tb_decode_output_queue;
  import decode_output_queue_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  decode_output_queue_if q_if ();

  decode_output_queue dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .q_if    (q_if)
  );

  // ---------------- drive / observe ----------------
  decoded_bundle_t drv_b, head_b;

  assign q_if.opcode_i             = drv_b.opcode;
  assign q_if.instructionAddress_i = drv_b.instruction_address;
  assign q_if.functionalUnitType_i = drv_b.functional_unit_type;
  assign q_if.instMajId_i          = drv_b.inst_maj_id;
  assign q_if.instMinId_i          = drv_b.inst_min_id;
  assign q_if.numMicroOps_i        = drv_b.num_micro_ops;
  assign q_if.is64Bit_i            = drv_b.is_64bit;
  assign q_if.instPid_i            = drv_b.inst_pid;
  assign q_if.instTid_i            = drv_b.inst_tid;
  assign q_if.op1rw_i              = drv_b.op1rw;
  assign q_if.op2rw_i              = drv_b.op2rw;
  assign q_if.op3rw_i              = drv_b.op3rw;
  assign q_if.op4rw_i              = drv_b.op4rw;
  assign q_if.op1IsReg_i           = drv_b.op1_is_reg;
  assign q_if.op2IsReg_i           = drv_b.op2_is_reg;
  assign q_if.op3IsReg_i           = drv_b.op3_is_reg;
  assign q_if.op4IsReg_i           = drv_b.op4_is_reg;
  assign q_if.modifiesCR_i         = drv_b.modifies_cr;
  assign q_if.instructionBody_i    = drv_b.instruction_body;

  always_comb begin
    head_b.opcode               = q_if.opcode_o;
    head_b.instruction_address  = q_if.instructionAddress_o;
    head_b.functional_unit_type = q_if.functionalUnitType_o;
    head_b.inst_maj_id          = q_if.instMajId_o;
    head_b.inst_min_id          = q_if.instMinId_o;
    head_b.num_micro_ops        = q_if.numMicroOps_o;
    head_b.is_64bit             = q_if.is64Bit_o;
    head_b.inst_pid             = q_if.instPid_o;
    head_b.inst_tid             = q_if.instTid_o;
    head_b.op1rw                = q_if.op1rw_o;
    head_b.op2rw                = q_if.op2rw_o;
    head_b.op3rw                = q_if.op3rw_o;
    head_b.op4rw                = q_if.op4rw_o;
    head_b.op1_is_reg           = q_if.op1IsReg_o;
    head_b.op2_is_reg           = q_if.op2IsReg_o;
    head_b.op3_is_reg           = q_if.op3IsReg_o;
    head_b.op4_is_reg           = q_if.op4IsReg_o;
    head_b.modifies_cr          = q_if.modifiesCR_o;
    head_b.instruction_body     = q_if.instructionBody_o;
  end

  // Every field of a stimulus bundle is derived from (opcode, majId), so the
  // expected head is rebuilt from the same pair.
  function automatic decoded_bundle_t make_bundle(input logic [11:0] op,
                                                  input logic [63:0] maj);
    decoded_bundle_t b;
    b.opcode               = op;
    b.instruction_address  = 64'h0000_4000_0000_1000 + (maj << 2);
    b.functional_unit_type = maj[2:0];
    b.inst_maj_id          = maj;
    b.inst_min_id          = maj[4:0] ^ 5'h15;
    b.num_micro_ops        = maj[4:0] + 5'd1;
    b.is_64bit             = maj[0];
    b.inst_pid             = 20'hABC00 + maj[19:0];
    b.inst_tid             = ~maj[15:0];
    b.op1rw                = maj[1:0];
    b.op2rw                = maj[3:2];
    b.op3rw                = ~maj[1:0];
    b.op4rw                = REG_READ_WRITE;
    b.op1_is_reg           = maj[0];
    b.op2_is_reg           = maj[1];
    b.op3_is_reg           = maj[2];
    b.op4_is_reg           = maj[3];
    b.modifies_cr          = maj[1];
    b.instruction_body     = maj[20:0] ^ 21'h1F0F0;
    return b;
  endfunction

  // ---------------- scoreboard ----------------
  int n_cmp;
  int n_bad;

  task automatic check(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        en;
    logic        rdy;
    logic        fl;
    logic [11:0] op;
    logic [63:0] maj;
    logic [3:0]  exp_count;
    logic        exp_valid;
    logic        exp_stall;
    logic        exp_ovf;
    logic [11:0] exp_op;
    logic [63:0] exp_maj;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic rdy, input logic fl,
                     input logic [11:0] op, input logic [63:0] maj,
                     input logic [3:0] c, input logic v, input logic s,
                     input logic o, input logic [11:0] eop,
                     input logic [63:0] emaj);
    vec_t t;
    t.en = en; t.rdy = rdy; t.fl = fl; t.op = op; t.maj = maj;
    t.exp_count = c; t.exp_valid = v; t.exp_stall = s; t.exp_ovf = o;
    t.exp_op = eop; t.exp_maj = emaj;
    vecs.push_back(t);
  endtask

  task automatic check_state(input string tag, input logic [3:0] c,
                             input logic v, input logic s, input logic o);
    check({tag, ".count"},    256'(q_if.count_o),    256'(c));
    check({tag, ".valid"},    256'(q_if.valid_o),    256'(v));
    check({tag, ".stall"},    256'(q_if.stall_o),    256'(s));
    check({tag, ".overflow"}, 256'(q_if.overflow_o), 256'(o));
  endtask

  task automatic drive_idle();
    q_if.enable_i = 1'b0;
    q_if.ready_i  = 1'b0;
    q_if.flush_i  = 1'b0;
    drv_b         = make_bundle(12'h000, 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive_idle();

    // Vector table
    add(1, 0, 0, 12'h0A5, 64'd7, 4'd1, 1, 0, 0, 12'h0A5, 64'd7);
    add(0, 1, 0, 12'h000, 64'd0, 4'd0, 0, 0, 0, 12'h000, 64'd0);
    for (int i = 0; i < 8; i++)
      add(1, 0, 0, 12'h100 + 12'(i), 64'(i), 4'(i + 1), 1, (i + 1) >= 6, 0,
          12'h100, 64'd0);
    // 9th push into a full queue: dropped, overflow sticks
    add(1, 0, 0, 12'h108, 64'd8, 4'd8, 1, 1, 1, 12'h100, 64'd0);
    // full queue, push+pop every cycle across the pointer wrap
    for (int j = 0; j < 16; j++)
      add(1, 1, 0, 12'h108 + 12'(j), 64'(8 + j), 4'd8, 1, 1, 1,
          12'h100 + 12'(j + 1), 64'(j + 1));
    // drain down to 5
    for (int k = 1; k <= 3; k++)
      add(0, 1, 0, 12'h000, 64'd0, 4'(8 - k), 1, (8 - k) >= 6, 1,
          12'h110 + 12'(k), 64'(16 + k));
    // flush with a simultaneous push
    add(1, 0, 1, 12'h3FF, 64'd99, 4'd0, 0, 0, 1, 12'h000, 64'd0);
    add(1, 0, 0, 12'h0C3, 64'd42, 4'd1, 1, 0, 1, 12'h0C3, 64'd42);
    add(1, 0, 0, 12'h0C4, 64'd43, 4'd2, 1, 0, 1, 12'h0C3, 64'd42);
    add(1, 0, 0, 12'h0C5, 64'd44, 4'd3, 1, 0, 1, 12'h0C3, 64'd42);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_state("reset", 4'd0, 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_state("idle", 4'd0, 0, 0, 0);

    foreach (vecs[n]) begin
      @(negedge clk);
      q_if.enable_i = vecs[n].en;
      q_if.ready_i  = vecs[n].rdy;
      q_if.flush_i  = vecs[n].fl;
      drv_b         = make_bundle(vecs[n].op, vecs[n].maj);
      @(posedge clk);
      #1;
      check_state($sformatf("vec%0d", n), vecs[n].exp_count, vecs[n].exp_valid,
                  vecs[n].exp_stall, vecs[n].exp_ovf);
      if (vecs[n].exp_valid)
        check($sformatf("vec%0d.head", n), 256'(head_b),
              256'(make_bundle(vecs[n].exp_op, vecs[n].exp_maj)));
    end

    // Head holds while ready is low (count 3, no push)
    @(negedge clk);
    drive_idle();
    @(posedge clk);
    #1;
    check("hold.head", 256'(head_b), 256'(make_bundle(12'h0C3, 64'd42)));
    check("hold.count", 256'(q_if.count_o), 256'(4'd3));

    // Asynchronous reset between edges at count 3
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("async_rst", 4'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Queue usable after reset
    @(negedge clk);
    q_if.enable_i = 1'b1;
    drv_b         = make_bundle(12'h05A, 64'd77);
    @(posedge clk);
    #1;
    check_state("post_rst", 4'd1, 1, 0, 0);
    check("post_rst.head", 256'(head_b), 256'(make_bundle(12'h05A, 64'd77)));
    @(negedge clk);
    drive_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
